arm_hazard_ctrl: RTL and testbench
==================================

Name: arm_hazard_ctrl

Overview:
- Drives the stall (write-enable) and flush (clear) inputs of every pipeline register in the ARM simple pipelined core: F/D, D/E, E/M and M/W.
- Combines three functions:
  - operand forwarding select;
  - load-use and branch/PC-write hazard detection;
  - a data-memory wait state machine that freezes the pipeline while the memory is not ready.
- Optional performance counters.
- Sits beside the datapath. Consumes register addresses and control bits from the D, E, M and W stages.

Parameters:
ADDR_W, 4, register-address width
MEM_TIMEOUT, 15, max consecutive memory-wait cycles before the error state (1..2^TO_W-1)
TO_W, 4, width of the wait counter
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
RA1D, RA2D  in  ADDR_W  source registers in D
RA1E, RA2E  in  ADDR_W  source registers in E
WA3E, WA3M, WA3W  in  ADDR_W  destination registers in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  register-write flags
MemtoRegE  in  1  load in E
PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-write flag per stage
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  load or store in M
MemReadyM  in  1  data memory completes this cycle
ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM
StallF, StallD, StallE, StallM  out  1  hold pipeline register (we = ~Stall)
FlushD, FlushE, FlushW  out  1  clear pipeline register (synchronous reset input)
mem_err  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt  out  CNT_W  performance counters (see Optional Feature)

Behaviour:
- Asynchronous reset (reset_n = 0):
  - FSM → IDLE; wait counter = 0; mem_err = 0; counters = 0.
  - Combinational outputs keep following their inputs.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && RA1E == WA3M.
  - Else 01 if RegWriteW && RA1E == WA3W.
  - Else 00.
  - M has priority over W.
  - RA1E == 4'hF (PC) always gives 00.
  - ForwardBE: same rules using RA2E.
- LDRstall = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E).
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Memory-wait FSM, states IDLE / WAIT / ERR:
  - IDLE:
    - MemReqM && !MemReadyM → WAIT, mem_stall = 1 in that same cycle.
    - Otherwise mem_stall = 0.
  - WAIT:
    - mem_stall = !MemReadyM. Wait counter increments each cycle.
    - MemReadyM → IDLE, counter cleared.
    - Counter reaches MEM_TIMEOUT while !MemReadyM → ERR.
  - ERR:
    - mem_stall = 1 permanently; mem_err = 1.
    - Exit only via reset_n.
  - MemReady and timeout in the same cycle: ready wins (→ IDLE).
- Output equations:
  - StallF = LDRstall | PCWrPendingF | mem_stall
  - StallD = LDRstall | mem_stall
  - StallE = StallM = mem_stall
  - FlushW = mem_stall (bubble into W; prevents a duplicate register write)
  - FlushD = !mem_stall && (PCWrPendingF | PCSrcW | BranchTakenE)
  - FlushE = !mem_stall && (LDRstall | BranchTakenE)
- Priority: mem_stall freezes the whole pipeline and masks FlushD/FlushE. Load-use and branch hazards are re-evaluated once the freeze ends.
- Load-use and BranchTakenE in the same cycle: both FlushE and StallD assert. The wrong-path instruction in D is squashed by FlushD.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with StallF = 1.
  - flush_cnt increments on every cycle with FlushD | FlushE.
  - Both saturate at 2^CNT_W − 1 and clear on reset.
- Undefined: no counter flops; stall_cnt and flush_cnt tied to 0.

Test Plan:
1. RegWriteM = 1, WA3M = 3, RA1E = 3; RegWriteW = 1, WA3W = 3 → ForwardAE = 10. Clear RegWriteM → ForwardAE = 01. RA1E = 15 with both matches → 00.
2. MemtoRegE = 1, RegWriteE = 1, WA3E = 5, RA2D = 5 → StallF = 1, StallD = 1, FlushE = 1 for exactly 1 cycle; ForwardBE = 10 the following cycle.
3. PCSrcD pulse propagated through E/M/W → StallF = 1 for 3 cycles, FlushD = 1 for 4 cycles; BranchTakenE = 1 → FlushD = FlushE = 1.
4. MemReqM = 1, MemReadyM low 3 cycles then high → StallF/D/E/M = FlushW = 1 for 3 cycles, released on the ready cycle; concurrent BranchTakenE yields FlushE = 0 while frozen.
5. MemReqM = 1, MemReadyM held low → ERR after MEM_TIMEOUT = 15 wait cycles, mem_err = 1 sticky; reset_n pulsed low mid-error → IDLE, mem_err = 0 immediately (asynchronous).
6. With HAZARD_PERF_CNT_EN, CNT_W = 4: 20 stall cycles → stall_cnt = 15 (saturated); without the macro both counters read 0.

Source files
------------

// File: rtl/arm_hazard_ctrl_if.sv
// arm_hazard_ctrl_if: hazard-unit bundle between the pipelined datapath (master) and the hazard controller (slave).
interface arm_hazard_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic              RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic              PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic              MemReqM, MemReadyM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushW, mem_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/arm_hazard_ctrl.sv
// arm_hazard_ctrl: forwarding, load-use/PC hazards and data-memory wait FSM for the ARM pipelined core.
// Optional saturating stall/flush counters enabled by HAZARD_PERF_CNT_EN.
module arm_hazard_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               reset_n,
  arm_hazard_ctrl_if.slave  hz
);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  localparam logic [ADDR_W-1:0] PC_REG = '1;
  state_t          r_state;
  logic [TO_W-1:0] r_wcnt;
  logic            r_err;
  logic            w_ldr_stall, w_pc_wr_pend, w_mem_stall;
  logic [TO_W-1:0] w_wcnt_nx;
  always_comb begin
    hz.ForwardAE = (hz.RA1E == PC_REG) ? 2'b00 :
                   (hz.RegWriteM && hz.RA1E == hz.WA3M) ? 2'b10 :
                   (hz.RegWriteW && hz.RA1E == hz.WA3W) ? 2'b01 : 2'b00;
    hz.ForwardBE = (hz.RA2E == PC_REG) ? 2'b00 :
                   (hz.RegWriteM && hz.RA2E == hz.WA3M) ? 2'b10 :
                   (hz.RegWriteW && hz.RA2E == hz.WA3W) ? 2'b01 : 2'b00;
  end
  assign w_ldr_stall  = hz.MemtoRegE && hz.RegWriteE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
  assign w_pc_wr_pend = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  // The first not-ready cycle stalls from IDLE so the access is frozen without a bubble.
  assign w_mem_stall  = (r_state == ERR) ||
                        (r_state == WAIT && !hz.MemReadyM) ||
                        (r_state == IDLE && hz.MemReqM && !hz.MemReadyM);
  assign w_wcnt_nx    = r_wcnt + 1'b1;
  assign hz.StallF  = w_ldr_stall | w_pc_wr_pend | w_mem_stall;
  assign hz.StallD  = w_ldr_stall | w_mem_stall;
  assign hz.StallE  = w_mem_stall;
  assign hz.StallM  = w_mem_stall;
  assign hz.FlushW  = w_mem_stall;
  assign hz.FlushD  = !w_mem_stall && (w_pc_wr_pend | hz.PCSrcW | hz.BranchTakenE);
  assign hz.FlushE  = !w_mem_stall && (w_ldr_stall | hz.BranchTakenE);
  assign hz.mem_err = r_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (hz.MemReqM && !hz.MemReadyM) begin
          r_state <= WAIT;
          r_wcnt  <= '0;
        end
        WAIT: if (hz.MemReadyM) begin
          r_state <= IDLE;
          r_wcnt  <= '0;
        end else begin
          r_wcnt <= w_wcnt_nx;
          if (w_wcnt_nx == TO_W'(MEM_TIMEOUT)) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end
        end
        ERR: r_err <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (hz.StallF && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((hz.FlushD || hz.FlushE) && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_arm_hazard_ctrl.sv
// tb_arm_hazard_ctrl: directed test-plan steps plus randomized traffic against a behavioural hazard model.
module tb_arm_hazard_ctrl;
  localparam int AW = 4, TO = 15, TW = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0, n_err = 0;
  bit m_wait, m_err;
  int m_waits, m_sc, m_fc;
  arm_hazard_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) hz();
  arm_hazard_ctrl #(.ADDR_W(AW), .MEM_TIMEOUT(TO), .TO_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .hz(hz)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (ra == 4'hF) return 2'b00;
    if (hz.RegWriteM && ra == hz.WA3M) return 2'b10;
    if (hz.RegWriteW && ra == hz.WA3W) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {hz.RA1D, hz.RA2D, hz.RA1E, hz.RA2E, hz.WA3E, hz.WA3M, hz.WA3W} = '0;
    {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE} = '0;
    {hz.PCSrcD, hz.PCSrcE, hz.PCSrcM, hz.PCSrcW, hz.BranchTakenE, hz.MemReqM, hz.MemReadyM} = '0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_waits = 0; m_sc = 0; m_fc = 0;
  endtask

  // Called right after a negedge with inputs applied: check, advance model past the posedge.
  task automatic cycle(input string tag);
    bit ldr, pcw, ms, sf, fd, fe;
    logic [12:0] exp_v, obs_v;
    #1;
    ldr = hz.MemtoRegE && hz.RegWriteE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
    pcw = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
    ms  = m_err || (m_wait ? !hz.MemReadyM : (hz.MemReqM && !hz.MemReadyM));
    sf  = ldr || pcw || ms;
    fd  = !ms && (pcw || hz.PCSrcW || hz.BranchTakenE);
    fe  = !ms && (ldr || hz.BranchTakenE);
    exp_v = {fwd(hz.RA1E), fwd(hz.RA2E), sf, ldr || ms, ms, ms, fd, fe, ms, m_err};
    obs_v = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
             hz.FlushD, hz.FlushE, hz.FlushW, hz.mem_err};
    chk(tag, 32'(obs_v), 32'(exp_v));
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_cnt"}, {8'd0, 8'(hz.stall_cnt), 8'd0, 8'(hz.flush_cnt)}, {8'd0, 8'(m_sc), 8'd0, 8'(m_fc)});
`else
    chk({tag, "_cnt"}, {8'd0, 8'(hz.stall_cnt), 8'd0, 8'(hz.flush_cnt)}, 32'd0);
`endif
    if (reset_n) begin
      if (!m_err) begin
        if (m_wait) begin
          if (hz.MemReadyM) m_wait = 0;
          else begin
            m_waits++;
            if (m_waits == TO) begin m_err = 1; m_wait = 0; end
          end
        end else if (hz.MemReqM && !hz.MemReadyM) begin
          m_wait = 1; m_waits = 0;
        end
      end
      if (sf && m_sc < CMAX) m_sc++;
      if ((fd || fe) && m_fc < CMAX) m_fc++;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic areset();
    clear_inputs();
    reset_n = 0;
    #1;
    chk("areset_err", 32'(hz.mem_err), 0);
    chk("areset_stall", 32'(hz.StallM), 0);
    model_reset();
    #1 reset_n = 1;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #1;
    chk("rst_err", 32'(hz.mem_err), 0);
    chk("rst_cnt", 32'({hz.stall_cnt, hz.flush_cnt}), 0);
    chk("rst_stall", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 0);
    @(negedge clk);
    reset_n = 1;
    // forwarding priority
    hz.RegWriteM = 1; hz.WA3M = 3; hz.RA1E = 3; hz.RegWriteW = 1; hz.WA3W = 3;
    #1 chk("fwdA_M", 32'(hz.ForwardAE), 2);
    cycle("t1a");
    hz.RegWriteM = 0;
    #1 chk("fwdA_W", 32'(hz.ForwardAE), 1);
    cycle("t1b");
    hz.RegWriteM = 1; hz.RA1E = 15; hz.WA3M = 15; hz.WA3W = 15;
    #1 chk("fwdA_pc", 32'(hz.ForwardAE), 0);
    cycle("t1c");
    clear_inputs();
    // load-use
    hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WA3E = 5; hz.RA2D = 5;
    #1 chk("ldr_sf_sd_fe", 32'({hz.StallF, hz.StallD, hz.FlushE}), 3'b111);
    cycle("t2a");
    clear_inputs();
    hz.RA2E = 5; hz.RegWriteM = 1; hz.WA3M = 5;
    #1 chk("ldr_after", 32'({hz.ForwardBE, hz.StallF, hz.FlushE}), 4'b1000);
    cycle("t2b");
    clear_inputs();
    // PC write travelling down the pipe
    hz.PCSrcD = 1; cycle("t3d");
    hz.PCSrcD = 0; hz.PCSrcE = 1; cycle("t3e");
    hz.PCSrcE = 0; hz.PCSrcM = 1; cycle("t3m");
    hz.PCSrcM = 0; hz.PCSrcW = 1;
    #1 chk("pcw_w", 32'({hz.StallF, hz.FlushD}), 2'b01);
    cycle("t3w");
    clear_inputs();
    hz.BranchTakenE = 1;
    #1 chk("br_flush", 32'({hz.FlushD, hz.FlushE}), 2'b11);
    cycle("t3b");
    // memory wait with branch masked
    hz.MemReqM = 1; hz.BranchTakenE = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_frozen", 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW, hz.FlushE}), 6'b111110);
      cycle("t4w");
    end
    hz.MemReadyM = 1;
    #1 chk("mw_release", 32'({hz.StallM, hz.FlushW, hz.FlushE}), 3'b001);
    cycle("t4r");
    clear_inputs();
    // timeout to ERR, then async reset
    hz.MemReqM = 1;
    for (int i = 0; i < 20; i++) cycle("t5");
    chk("err_sticky", 32'({hz.mem_err, hz.StallM}), 2'b11);
    areset();
    // counter saturation
    hz.PCSrcD = 1;
    for (int i = 0; i < 20; i++) cycle("t6");
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_sat", 32'(hz.stall_cnt), CMAX);
`else
    chk("stall_off", 32'(hz.stall_cnt), 0);
`endif
    clear_inputs();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) areset();
      {hz.RA1D, hz.RA2D, hz.RA1E, hz.RA2E} = 16'($urandom);
      {hz.WA3E, hz.WA3M, hz.WA3W} = 12'($urandom);
      {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE} = 4'($urandom);
      hz.PCSrcD = ($urandom_range(0, 7) == 0);
      hz.PCSrcE = ($urandom_range(0, 7) == 0);
      hz.PCSrcM = ($urandom_range(0, 7) == 0);
      hz.PCSrcW = ($urandom_range(0, 7) == 0);
      hz.BranchTakenE = ($urandom_range(0, 5) == 0);
      hz.MemReqM = ($urandom_range(0, 2) == 0);
      hz.MemReadyM = (i >= 300 && i < 330) ? 1'b0 : ($urandom_range(0, 2) != 0);
      cycle("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
